// File: rtl/turn_executor_if.sv
// Purpose : bundles the decision-stage to turn-executor signals (commands in, motor/status out).
// Latency : pure wiring, no storage.
// Backpressure: none; the executor ignores requests while busy and reports that on is_turning.
// Ports (all 1 bit):
//   enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, forward_req  : decision stage -> executor
//   is_turning, motor_forward, motor_turn_left, motor_turn_right, turn_done        : executor -> decision stage / motors
interface turn_executor_if;
    logic enable;
    logic trigger_turn_left;
    logic trigger_turn_right;
    logic trigger_turn_back;
    logic forward_req;
    logic is_turning;
    logic motor_forward;
    logic motor_turn_left;
    logic motor_turn_right;
    logic turn_done;

    // Decision-stage side
    modport master (
        output enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, forward_req,
        input  is_turning, motor_forward, motor_turn_left, motor_turn_right, turn_done
    );

    // Executor side
    modport slave (
        input  enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, forward_req,
        output is_turning, motor_forward, motor_turn_left, motor_turn_right, turn_done
    );
endinterface

// File: rtl/turn_executor.sv
// Purpose : runs a timed turn (left/right/back) then a forward exit phase, and drives the motor commands.
// Latency : all outputs registered; a trigger or forward_req shows on the motors one cycle later.
// Backpressure: none; triggers/forward_req during a manoeuvre are dropped (not queued), is_turning flags busy.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (wins over enable)
//   bus  : turn_executor_if.slave (commands in, motor/status out)
module turn_executor #(
    parameter int TURN_TICKS = 450,
    parameter int BACK_TICKS = 900,
    parameter int EXIT_TICKS = 250,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    turn_executor_if.slave        bus
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] BACK_LOAD = CNT_W'(BACK_TICKS - 1);
    localparam logic [CNT_W-1:0] EXIT_LOAD = CNT_W'(EXIT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        EXIT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_turning_q;
    logic             motor_forward_q;
    logic             motor_turn_left_q;
    logic             motor_turn_right_q;
    logic             turn_done_q;

    always_ff @(posedge clk) begin
        // Dropping enable is a forced idle: aborts a manoeuvre without turn_done.
        if (rst || !bus.enable) begin
            state              <= IDLE;
            cnt                <= '0;
            is_turning_q       <= 1'b0;
            motor_forward_q    <= 1'b0;
            motor_turn_left_q  <= 1'b0;
            motor_turn_right_q <= 1'b0;
            turn_done_q        <= 1'b0;
        end else begin
            turn_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Priority back > left > right. A back turn rotates left for twice as long.
                    if (bus.trigger_turn_back || bus.trigger_turn_left || bus.trigger_turn_right) begin
                        state              <= TURN;
                        is_turning_q       <= 1'b1;
                        motor_forward_q    <= 1'b0;
                        cnt                <= bus.trigger_turn_back ? BACK_LOAD : TURN_LOAD;
                        motor_turn_left_q  <= bus.trigger_turn_back || bus.trigger_turn_left;
                        motor_turn_right_q <= !bus.trigger_turn_back && !bus.trigger_turn_left;
                    end else begin
                        is_turning_q       <= 1'b0;
                        motor_forward_q    <= bus.forward_req;
                        motor_turn_left_q  <= 1'b0;
                        motor_turn_right_q <= 1'b0;
                    end
                end
                TURN: begin
                    if (cnt == '0) begin
                        state              <= EXIT;
                        cnt                <= EXIT_LOAD;
                        motor_turn_left_q  <= 1'b0;
                        motor_turn_right_q <= 1'b0;
                        motor_forward_q    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EXIT: begin
                    if (cnt == '0) begin
                        state           <= IDLE;
                        is_turning_q    <= 1'b0;
                        turn_done_q     <= 1'b1;
                        motor_forward_q <= bus.forward_req;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state              <= IDLE;
                    cnt                <= '0;
                    is_turning_q       <= 1'b0;
                    motor_forward_q    <= 1'b0;
                    motor_turn_left_q  <= 1'b0;
                    motor_turn_right_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.is_turning       = is_turning_q;
    assign bus.motor_forward    = motor_forward_q;
    assign bus.motor_turn_left  = motor_turn_left_q;
    assign bus.motor_turn_right = motor_turn_right_q;
    assign bus.turn_done        = turn_done_q;

endmodule

// File: tb/tb_turn_executor.sv
module tb_turn_executor;
    localparam int TT = 4;
    localparam int BT = 8;
    localparam int ET = 3;

    // Expected-output encoding: {is_turning, motor_forward, motor_turn_left, motor_turn_right, turn_done}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_FWD   = 5'b01000;
    localparam logic [4:0] O_LEFT  = 5'b10100;
    localparam logic [4:0] O_RIGHT = 5'b10010;
    localparam logic [4:0] O_EXIT  = 5'b11000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    turn_executor_if bus ();

    turn_executor #(
        .TURN_TICKS(TT),
        .BACK_TICKS(BT),
        .EXIT_TICKS(ET),
        .CNT_W     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [4:0] observed();
        return {bus.is_turning, bus.motor_forward, bus.motor_turn_left,
                bus.motor_turn_right, bus.turn_done};
    endfunction

    function automatic void push(input logic [4:0] v);
        exp_q.push_back(v);
    endfunction

    // Expected trace for a complete manoeuvre started by a trigger at the next edge.
    function automatic void push_turn(input bit right, input int ticks, input logic fwd_after);
        for (int i = 0; i < ticks; i++) push(right ? O_RIGHT : O_LEFT);
        for (int i = 0; i < ET; i++) push(O_EXIT);
        push({1'b0, fwd_after, 3'b001});
    endfunction

    task automatic check_out(input string tag);
        logic [4:0] o;
        logic [4:0] e;
        o = observed();
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed=%b", tag, o);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed=%b expected=%b", tag, o, e);
            end
        end
        checks++;
        assert ($onehot0(o[3:1])) else begin
            errors++;
            $error("FAIL %s_onehot: motors observed=%b expected at most one high", tag, o[3:1]);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic step(input string tag, input logic en, input logic l, input logic r,
                        input logic b, input logic f);
        bus.enable             = en;
        bus.trigger_turn_left  = l;
        bus.trigger_turn_right = r;
        bus.trigger_turn_back  = b;
        bus.forward_req        = f;
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.trigger_turn_left = 1'b0;
        bus.trigger_turn_right = 1'b0;
        bus.trigger_turn_back = 1'b0;
        bus.forward_req = 1'b0;

        // 1: reset with random inputs
        repeat (2) begin
            push(O_IDLE);
            step("reset", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        push(O_IDLE);
        step("idle_after_reset", 1, 0, 0, 0, 0);

        // 2: left turn
        push_turn(0, TT, 0);
        step("left_trig", 1, 1, 0, 0, 0);
        repeat (TT + ET) step("left_run", 1, 0, 0, 0, 0);

        // 3: back turn, then right turn
        push_turn(0, BT, 0);
        step("back_trig", 1, 0, 0, 1, 0);
        repeat (BT + ET) step("back_run", 1, 0, 0, 0, 0);
        push_turn(1, TT, 0);
        step("right_trig", 1, 0, 1, 0, 0);
        repeat (TT + ET) step("right_run", 1, 0, 0, 0, 0);

        // 4: all triggers together -> back; right trigger mid-turn ignored
        push_turn(0, BT, 0);
        step("all_trig", 1, 1, 1, 1, 0);
        step("prio_run", 1, 0, 0, 0, 0);
        step("ign_right", 1, 0, 1, 0, 0);
        repeat (BT + ET - 2) step("prio_run", 1, 0, 0, 0, 0);
        repeat (3) begin
            push(O_IDLE);
            step("no_second_turn", 1, 0, 0, 0, 0);
        end

        // 5: enable dropped in cycle 3 of a turn, then a fresh turn
        repeat (3) push(O_LEFT);
        step("abort_trig", 1, 1, 0, 0, 0);
        repeat (2) step("abort_run", 1, 0, 0, 0, 0);
        push(O_IDLE);
        step("en_drop", 0, 0, 0, 0, 0);
        repeat (2) begin
            push(O_IDLE);
            step("forced_idle", 0, 1, 0, 0, 1);
        end
        push_turn(0, TT, 0);
        step("fresh_trig", 1, 1, 0, 0, 0);
        repeat (TT + ET) step("fresh_run", 1, 0, 0, 0, 0);

        // 5b: reset in cycle 3 of a right turn
        repeat (3) push(O_RIGHT);
        step("rabort_trig", 1, 0, 1, 0, 0);
        repeat (2) step("rabort_run", 1, 0, 0, 0, 0);
        rst = 1'b1;
        push(O_IDLE);
        step("rst_abort", 1, 0, 0, 0, 0);
        rst = 1'b0;
        push(O_IDLE);
        step("idle_after_rst", 1, 0, 0, 0, 0);

        // 6: forward_req in IDLE, and toggled during a turn
        push(O_FWD);
        step("fwd_idle", 1, 0, 0, 0, 1);
        push(O_IDLE);
        step("fwd_off", 1, 0, 0, 0, 0);
        push_turn(1, TT, 1);
        step("fwd_turn_trig", 1, 0, 1, 0, 1);
        for (int i = 0; i < TT + ET; i++)
            step("fwd_toggle_run", 1, 0, 0, 0, (i % 2 == 0) ? 1'b1 : 1'b0);
        push(O_IDLE);
        step("fwd_end", 1, 0, 0, 0, 0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed=%0d leftover expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
